// File: rtl/io_bus_pkg.sv
// io_bus_pkg: region map, master/owner encoding and FSM states shared by the IO bus arbiter.
// The read-return tag travels down the return pipe alongside each issued read beat.
package io_bus_pkg;

   localparam logic [11:0] REG_DMEM   = 12'h001;
   localparam logic [11:0] REG_VGA    = 12'h002;
   localparam logic [11:0] REG_KEY    = 12'h003;
   localparam logic [11:0] REG_OFFS   = 12'h004;
   localparam logic [11:0] REG_COLOR  = 12'h005;
   localparam logic [11:0] REG_CURSOR = 12'h006;
   localparam logic [11:0] REG_TIMER  = 12'h007;
   localparam logic [11:0] REG_HEAP   = 12'h008;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   err;
   } rd_tag_t;

   function automatic logic is_key_region(input logic [31:0] addr);
      return addr[31:20] == REG_KEY;
   endfunction

endpackage

// File: rtl/io_rd_return_pipe.sv
// io_rd_return_pipe: RD_LAT-deep shift of read tags; the tag at the last stage lines up
// with the cycle in which the decoder presents that beat's bus_rdata.
module io_rd_return_pipe
   import io_bus_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t push_i,
   output rd_tag_t pop_o
);

   rd_tag_t stage_q [RD_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: every stage is cleared, not just the valid bits' consumer, so reads in flight at reset are dropped.
         for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let each stage take its predecessor's old value in the same edge.
         stage_q[0] <= push_i;
         for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign pop_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin sharing of the MMIO/data bus between CPU (M0) and blit engine (M1).
// Define IO_ARB_BURST_EN to let the owner hold the bus for up to MAX_BURST beats under contention.
module io_bus_arbiter
   import io_bus_pkg::*;
#(
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_en,
   input  logic [31:0] bus_rdata
);

`ifdef IO_ARB_BURST_EN
   localparam int BURST_LIM = MAX_BURST;
`else
   localparam int BURST_LIM = 1;
`endif
   localparam int               CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LIM - 1);

   state_e           state_q, state_d;
   owner_e           rr_ptr_q, rr_ptr_d, win, cur_own;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             any_gnt, keep_owner, key_rej, drive, sel_we;
   logic [31:0]      sel_addr, sel_wdata, ret_data, m0_rdata_q, m1_rdata_q;
   rd_tag_t          push_tag, pop_tag;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      cur_own    = (state_q == ST_OWN1) ? OWN_M1 : OWN_M0;
      keep_owner = (state_q != ST_IDLE) && (cnt_q != CNT_MAX);
      win        = rr_ptr_q;
      if (m0_req && m1_req) begin
         if (keep_owner) win = cur_own;
      end else if (m1_req) begin
         win = OWN_M1;
      end else begin
         win = OWN_M0;
      end
      any_gnt  = (m0_req || m1_req) && !rst;
      state_d  = ST_IDLE;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = '0;
      if (any_gnt) begin
         state_d  = (win == OWN_M1) ? ST_OWN1 : ST_OWN0;
         rr_ptr_d = (win == OWN_M1) ? OWN_M0 : OWN_M1;
         // A lone requester keeps streaming; its count saturates so contention switches at once.
         if ((state_q != ST_IDLE) && (win == cur_own)) cnt_d = keep_owner ? cnt_q + 1'b1 : cnt_q;
      end
   end

   always_comb begin
      sel_we    = (win == OWN_M1) ? m1_we    : m0_we;
      sel_addr  = (win == OWN_M1) ? m1_addr  : m0_addr;
      sel_wdata = (win == OWN_M1) ? m1_wdata : m0_wdata;
      key_rej   = any_gnt && (win == OWN_M1) && is_key_region(m1_addr);
      drive     = any_gnt && !key_rej;
      // Parking at 0 keeps the decoder out of the key region, so no spurious key pop.
      bus_addr  = drive ? sel_addr  : '0;
      bus_wdata = drive ? sel_wdata : '0;
      bus_en    = drive && sel_we;
      m0_gnt    = any_gnt && (win == OWN_M0);
      m1_gnt    = any_gnt && (win == OWN_M1);
      m1_err    = key_rej;
      push_tag  = '{valid: any_gnt && !sel_we, owner: win, err: key_rej};
   end

   io_rd_return_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
      .clk    (clk),
      .rst    (rst),
      .push_i (push_tag),
      .pop_o  (pop_tag)
   );

   assign ret_data  = pop_tag.err ? '0 : bus_rdata;
   assign m0_rvalid = pop_tag.valid && (pop_tag.owner == OWN_M0) && !rst;
   assign m1_rvalid = pop_tag.valid && (pop_tag.owner == OWN_M1) && !rst;
   assign m0_rdata  = rst ? '0 : (m0_rvalid ? ret_data : m0_rdata_q);
   assign m1_rdata  = rst ? '0 : (m1_rvalid ? ret_data : m1_rdata_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= OWN_M0;
         cnt_q      <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         m0_rdata_q <= m0_rdata;
         m1_rdata_q <= m1_rdata;
      end
   end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed and randomized traffic checked every cycle against a
// transaction-level model of round-robin grants, key rejection and in-order read return.
module tb_io_bus_arbiter;

   localparam int RD_LAT    = 2;
   localparam int MAX_BURST = 4;
`ifdef IO_ARB_BURST_EN
   localparam int LIMIT = MAX_BURST;
`else
   localparam int LIMIT = 1;
`endif
   localparam logic [11:0] KEY_REGION = 12'h003;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, bus_rdata = '0;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m1_err, bus_en;
   logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;

   io_bus_arbiter #(.RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_en(bus_en), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // Master-side request state: a beat is held until the model sees it granted.
   bit          pend [2];
   bit          we_v [2];
   logic [31:0] addr_v [2];
   logic [31:0] wdata_v [2];
   int          rate [2];
   int          we_pct, key_pct;
   bit          rnd_rdata, rst_req;
   logic [31:0] fixed_rdata;

   typedef struct {
      int owner;
      bit err;
      int due;
   } ret_t;

   ret_t        rq [$];
   int          last_served, prev_own, streak, cyc;
   logic [31:0] hold [2];
   int          n_cmp, n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic direct_req(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      pend[i]    = 1'b1;
      we_v[i]    = we;
      addr_v[i]  = addr;
      wdata_v[i] = wdata;
   endtask

   task automatic new_req(input int i);
      logic [11:0] region;
      if (int'($urandom_range(99)) < key_pct) region = KEY_REGION;
      else region = 12'($urandom_range(8, 1));
      direct_req(i, int'($urandom_range(99)) < we_pct, {region, 20'($urandom())}, $urandom());
   endtask

   task automatic model_and_check();
      int          win;
      bit          key, drive;
      bit          e_rv [2];
      ret_t        r;
      logic [31:0] e_addr, e_wdata;
      e_rv[0] = 1'b0;
      e_rv[1] = 1'b0;
      win     = -1;
      if (rst) begin
         rq.delete();
         last_served = 1;
         prev_own    = -1;
         streak      = 0;
         hold[0]     = '0;
         hold[1]     = '0;
      end else begin
         if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            e_rv[r.owner]  = 1'b1;
            hold[r.owner]  = r.err ? 32'h0 : bus_rdata;
         end
         if (pend[0] && pend[1]) win = (prev_own >= 0 && streak < LIMIT) ? prev_own : 1 - last_served;
         else if (pend[0]) win = 0;
         else if (pend[1]) win = 1;
      end
      key     = (win == 1) && (addr_v[1][31:20] == KEY_REGION);
      drive   = (win >= 0) && !key;
      e_addr  = drive ? addr_v[win]  : 32'h0;
      e_wdata = drive ? wdata_v[win] : 32'h0;
      check("m0_gnt",    32'(m0_gnt),    32'(win == 0));
      check("m1_gnt",    32'(m1_gnt),    32'(win == 1));
      check("m1_err",    32'(m1_err),    32'(key));
      check("bus_addr",  bus_addr,       e_addr);
      check("bus_wdata", bus_wdata,      e_wdata);
      check("bus_en",    32'(bus_en),    32'(drive && we_v[win]));
      check("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
      check("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
      check("m0_rdata",  m0_rdata,       hold[0]);
      check("m1_rdata",  m1_rdata,       hold[1]);
      if (win >= 0) begin
         streak      = (win == prev_own) ? streak + 1 : 1;
         prev_own    = win;
         last_served = win;
         if (!we_v[win]) rq.push_back('{owner: win, err: key, due: cyc + RD_LAT});
         pend[win] = 1'b0;
      end else if (!rst) begin
         prev_own = -1;
         streak   = 0;
      end
      cyc++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rst = rst_req;
      for (int i = 0; i < 2; i++)
         if (!pend[i] && int'($urandom_range(99)) < rate[i]) new_req(i);
      bus_rdata = rnd_rdata ? $urandom() : fixed_rdata;
      m0_req = pend[0]; m0_we = we_v[0]; m0_addr = addr_v[0]; m0_wdata = wdata_v[0];
      m1_req = pend[1]; m1_we = we_v[1]; m1_addr = addr_v[1]; m1_wdata = wdata_v[1];
      @(negedge clk);
      model_and_check();
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0;
      last_served = 1; prev_own = -1; streak = 0;
      hold[0] = '0; hold[1] = '0;
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0; rate[i] = 0;
      end
      we_pct = 50; key_pct = 0; rnd_rdata = 1'b0; fixed_rdata = '0;

      // Reset with no traffic: everything quiet and parked.
      rst_req = 1'b1;
      repeat (3) step();
      rst_req = 1'b0;

      // Lone M0 read returns the decoder's data RD_LAT cycles later.
      fixed_rdata = 32'hDEAD_BEEF;
      direct_req(0, 1'b0, 32'h0010_0004, 32'h0);
      repeat (RD_LAT + 3) step();

      // Fresh reset, then both masters stream writes: round-robin starts at M0.
      rst_req = 1'b1;
      step();
      rst_req   = 1'b0;
      rnd_rdata = 1'b1;
      we_pct    = 100;
      rate[0]   = 100; rate[1] = 100;
      repeat (40) step();
      rate[0] = 0;
      repeat (20) step();
      rate[1] = 0;
      repeat (4) step();

      // Key region: rejected for M1, forwarded for M0.
      direct_req(1, 1'b0, 32'h0030_0000, 32'h0);
      repeat (RD_LAT + 2) step();
      direct_req(0, 1'b0, 32'h0030_0000, 32'h0);
      repeat (RD_LAT + 2) step();

      // Two reads in flight when reset hits: neither may come back.
      direct_req(0, 1'b0, 32'h0010_0040, 32'h0);
      direct_req(1, 1'b0, 32'h0080_0100, 32'h0);
      repeat (2) step();
      rst_req = 1'b1;
      repeat (2) step();
      rst_req = 1'b0;
      repeat (RD_LAT + 3) step();

      // Random mixed traffic with occasional reset while reads are outstanding.
      we_pct  = 50;
      key_pct = 10;
      for (int n = 0; n < 3000; n++) begin
         if (n % 100 == 0) begin
            rate[0] = 30 * int'($urandom_range(3, 0));
            rate[1] = 30 * int'($urandom_range(3, 0));
         end
         rst_req = (rq.size() >= 2) && (int'($urandom_range(99)) < 2);
         step();
      end
      rst_req = 1'b0;
      rate[0] = 0; rate[1] = 0;
      repeat (RD_LAT + 4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
